// File: rtl/dispatch_queue.sv
// Dispatch queue between rename and the ROB: 16-entry circular buffer,
// up to 4 compacted enqueues and 4 in-order ROB inserts per cycle.
//
// Ports:
//   clk, reset (sync, active-low)
//   in_valid[3:0], in_archReg0..3[4:0], in_physReg0..3[7:0],
//   in_opcode0..3[10:0]               decode lanes
//   rob_full, flush                   control
//   in_ready                          at least 4 entries free
//   inserted[3:0], archReg0..3, physReg0..3, opcode0..3
//                                     ROB insert lanes (zero when idle)
//   count[4:0]                        occupied entries 0..16
module dispatch_queue #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_valid,
  input  logic [4:0]  in_archReg0,
  input  logic [4:0]  in_archReg1,
  input  logic [4:0]  in_archReg2,
  input  logic [4:0]  in_archReg3,
  input  logic [7:0]  in_physReg0,
  input  logic [7:0]  in_physReg1,
  input  logic [7:0]  in_physReg2,
  input  logic [7:0]  in_physReg3,
  input  logic [10:0] in_opcode0,
  input  logic [10:0] in_opcode1,
  input  logic [10:0] in_opcode2,
  input  logic [10:0] in_opcode3,
  input  logic        rob_full,
  input  logic        flush,
  output logic        in_ready,
  output logic [3:0]  inserted,
  output logic [4:0]  archReg0,
  output logic [4:0]  archReg1,
  output logic [4:0]  archReg2,
  output logic [4:0]  archReg3,
  output logic [7:0]  physReg0,
  output logic [7:0]  physReg1,
  output logic [7:0]  physReg2,
  output logic [7:0]  physReg3,
  output logic [10:0] opcode0,
  output logic [10:0] opcode1,
  output logic [10:0] opcode2,
  output logic [10:0] opcode3,
  output logic [4:0]  count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  arch;
    logic [7:0]  phys;
    logic [10:0] op;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [4:0]      count_q, count_d;

  entry_t          lane_in  [WIDTH];
  entry_t          lane_out [WIDTH];

  logic            enq_ok;
  logic [AW-1:0]   off;
  logic [2:0]      enq;
  logic [2:0]      deq;

  assign lane_in[0] = '{in_archReg0, in_physReg0, in_opcode0};
  assign lane_in[1] = '{in_archReg1, in_physReg1, in_opcode1};
  assign lane_in[2] = '{in_archReg2, in_physReg2, in_opcode2};
  assign lane_in[3] = '{in_archReg3, in_physReg3, in_opcode3};

  // Room for a full 4-lane group is judged on the registered count only.
  assign in_ready = (count_q <= 5'd12);
  assign enq_ok   = in_ready & ~flush;
  assign count    = count_q;

  always_comb begin
    if (rob_full || flush)
      deq = 3'd0;
    else if (count_q >= 5'd4)
      deq = 3'd4;
    else
      deq = count_q[2:0];
  end

  // Contiguous insert mask; idle lanes drive a zero payload.
  always_comb begin
    inserted = '0;
    for (int k = 0; k < WIDTH; k++) begin
      inserted[k] = (3'(k) < deq);
      lane_out[k] = inserted[k] ? mem_q[head_q + AW'(k)] : '0;
    end
  end

  assign archReg0 = lane_out[0].arch;
  assign archReg1 = lane_out[1].arch;
  assign archReg2 = lane_out[2].arch;
  assign archReg3 = lane_out[3].arch;
  assign physReg0 = lane_out[0].phys;
  assign physReg1 = lane_out[1].phys;
  assign physReg2 = lane_out[2].phys;
  assign physReg3 = lane_out[3].phys;
  assign opcode0  = lane_out[0].op;
  assign opcode1  = lane_out[1].op;
  assign opcode2  = lane_out[2].op;
  assign opcode3  = lane_out[3].op;

  // Compaction: each valid lane lands at tail plus the number of
  // valid lanes below it, so gaps in in_valid never occupy entries.
  always_comb begin
    for (int e = 0; e < DEPTH; e++)
      mem_d[e] = mem_q[e];
    off = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (enq_ok && in_valid[i]) begin
        mem_d[tail_q + off] = lane_in[i];
        off = off + AW'(1);
      end
    end
    enq = off[2:0];
  end

  always_comb begin
    head_d  = head_q + AW'(deq);
    tail_d  = tail_q + AW'(enq);
    count_d = count_q + {2'b00, enq} - {2'b00, deq};
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++)
        mem_q[e] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int e = 0; e < DEPTH; e++)
        mem_q[e] <= mem_d[e];
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_dispatch_queue;

  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [4:0]  a_i [4];
  logic [7:0]  p_i [4];
  logic [10:0] o_i [4];
  logic        rob_full;
  logic        flush;
  logic        in_ready;
  logic [3:0]  inserted;
  logic [4:0]  a_o [4];
  logic [7:0]  p_o [4];
  logic [10:0] o_o [4];
  logic [4:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  logic [23:0] q [$];
  logic [10:0] rx [$];

  dispatch_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_archReg0(a_i[0]), .in_archReg1(a_i[1]),
    .in_archReg2(a_i[2]), .in_archReg3(a_i[3]),
    .in_physReg0(p_i[0]), .in_physReg1(p_i[1]),
    .in_physReg2(p_i[2]), .in_physReg3(p_i[3]),
    .in_opcode0(o_i[0]), .in_opcode1(o_i[1]),
    .in_opcode2(o_i[2]), .in_opcode3(o_i[3]),
    .rob_full(rob_full), .flush(flush),
    .in_ready(in_ready), .inserted(inserted),
    .archReg0(a_o[0]), .archReg1(a_o[1]),
    .archReg2(a_o[2]), .archReg3(a_o[3]),
    .physReg0(p_o[0]), .physReg1(p_o[1]),
    .physReg2(p_o[2]), .physReg3(p_o[3]),
    .opcode0(o_o[0]), .opcode1(o_o[1]),
    .opcode2(o_o[2]), .opcode3(o_o[3]),
    .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_deq();
    if (rob_full || flush) return 0;
    return (q.size() > 4) ? 4 : q.size();
  endfunction

  // Compare outputs with the model, before the edge.
  task automatic probe();
    int d;
    logic [23:0] e;
    #1;
    if (chk_en) begin
      d = model_deq();
      check("count", 32'(count), 32'(q.size()));
      check("in_ready", 32'(in_ready), 32'(q.size() <= 12));
      check("inserted", 32'(inserted), 32'((1 << d) - 1));
      for (int k = 0; k < 4; k++) begin
        e = (k < d) ? q[k] : 24'h0;
        check($sformatf("lane%0d", k),
              32'({a_o[k], p_o[k], o_o[k]}), 32'(e));
      end
      for (int k = 0; k < 4; k++)
        if (inserted[k]) rx.push_back(o_o[k]);
    end
  endtask

  task automatic advance();
    int d;
    bit rdy;
    d   = model_deq();
    rdy = (q.size() <= 12);
    @(posedge clk);
    if (!reset || flush) begin
      q.delete();
    end else begin
      repeat (d) void'(q.pop_front());
      if (rdy)
        for (int i = 0; i < 4; i++)
          if (in_valid[i]) q.push_back({a_i[i], p_i[i], o_i[i]});
    end
    @(negedge clk);
    chk_en = 1;
  endtask

  task automatic tick();
    probe();
    advance();
  endtask

  task automatic idle();
    reset = 1; flush = 0; rob_full = 0; in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      a_i[i] = 0; p_i[i] = 0; o_i[i] = 0;
    end
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < 4; i++) begin
      a_i[i] = 5'($urandom);
      p_i[i] = 8'($urandom);
      o_i[i] = 11'($urandom);
    end
  endtask

  initial begin
    idle();
    reset = 0;
    @(negedge clk);
    advance();
    // reset state
    idle();
    reset = 0;
    tick();
    idle();
    probe();
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_ins", 32'(inserted), 0);
    advance();

    // four lanes in while the ROB is full, then drain
    rand_lanes();
    in_valid = 4'b1111; rob_full = 1;
    for (int i = 0; i < 4; i++) o_i[i] = 11'(i + 1);
    tick();
    in_valid = 0;
    probe();
    check("r33_count", 32'(count), 4);
    check("r33_ins_hold", 32'(inserted), 0);
    advance();
    rob_full = 0;
    probe();
    check("r33_ins", 32'(inserted), 4'b1111);
    check("r33_op3", 32'(o_o[3]), 4);
    advance();
    probe();
    check("r33_drained", 32'(count), 0);
    advance();

    // sparse lanes compact to the low ROB lanes
    rand_lanes();
    in_valid = 4'b1010; o_i[1] = 7; o_i[3] = 9;
    tick();
    in_valid = 0;
    probe();
    check("r34_ins", 32'(inserted), 4'b0011);
    check("r34_op0", 32'(o_o[0]), 7);
    check("r34_op1", 32'(o_o[1]), 9);
    check("r34_op2", 32'(o_o[2]), 0);
    advance();
    tick();

    // fill to 16 and drop a fifth burst
    rob_full = 1;
    for (int b = 0; b < 5; b++) begin
      rand_lanes();
      in_valid = 4'b1111;
      tick();
    end
    in_valid = 0;
    probe();
    check("r35_full", 32'(count), 16);
    check("r35_ready", 32'(in_ready), 0);
    advance();

    // steady 4-in / 4-out across pointer wrap
    reset = 0; rob_full = 0; tick();
    reset = 1; rx.delete();
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 10) ? 4'b1111 : 4'b0000;
      for (int i = 0; i < 4; i++) o_i[i] = 11'(c * 4 + i + 1);
      tick();
    end
    tick();
    check("r36_len", 32'(rx.size()), 40);
    for (int n = 0; n < 40 && n < rx.size(); n++)
      check($sformatf("r36_op%0d", n), 32'(rx[n]), 32'(n + 1));

    // flush at count 9 with a full lane group pending
    rob_full = 1;
    rand_lanes(); in_valid = 4'b1111; tick();
    rand_lanes(); tick();
    rand_lanes(); in_valid = 4'b0001; tick();
    rob_full = 0; flush = 1; in_valid = 4'b1111;
    probe();
    check("r37_count9", 32'(count), 9);
    check("r37_ins", 32'(inserted), 0);
    advance();
    flush = 0; in_valid = 0; rob_full = 1;
    probe();
    check("r37_count", 32'(count), 0);
    check("r37_ready", 32'(in_ready), 1);
    advance();

    // mid-stream reset at count 6
    rand_lanes(); in_valid = 4'b1111; tick();
    rand_lanes(); in_valid = 4'b0011; tick();
    in_valid = 0; reset = 0; rob_full = 0;
    probe();
    check("r38_count6", 32'(count), 6);
    advance();
    reset = 1;
    probe();
    check("r38_count", 32'(count), 0);
    check("r38_ins", 32'(inserted), 0);
    advance();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rand_lanes();
      in_valid = 4'($urandom);
      rob_full = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 49) == 0);
      reset    = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
